// File: rtl/mem_access_stage.sv
// Memory-access stage: forwards non-memory results, runs one req/ack bus
// transaction at a time for loads/stores, and aborts a hung bus after TIMEOUT cycles.
module mem_access_stage #(
  parameter int W_OPR   = 32,
  parameter int ADDR    = 16,
  parameter int W_RD    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             memf_i,
  input  logic             write_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [W_OPR-1:0] data_i,
  input  logic [W_OPR-1:0] res_i,
  input  logic             wbf_i,
  input  logic [W_RD-1:0]  rd_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [W_OPR-1:0] mem_rdata_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W_OPR-1:0] result_o,
  output logic             wbf_o,
  output logic [W_RD-1:0]  rd_o,
  output logic             err_o
);

  localparam int CW = 8;

  typedef enum logic {IDLE, BUS} state_t;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [ADDR-1:0]  addr;
    logic [W_OPR-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic             vld;
    logic [W_OPR-1:0] result;
    logic             wbf;
    logic [W_RD-1:0]  rd;
    logic             err;
  } wb_rsp_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W_RD-1:0] rd_q;
  bus_req_t        bus_q;
  wb_rsp_t         rsp_q;
  logic            accept;
  logic            tmo;

  assign ready_o = (state == IDLE) && (!rsp_q.vld || ready_i);
  assign accept  = valid_i && ready_o;
  // Ack has priority: timeout only fires on a cycle with no ack.
  assign tmo     = (state == BUS) && !mem_ack_i && (cnt == CW'(TIMEOUT - 1));

  assign mem_req_o   = bus_q.req;
  assign mem_we_o    = bus_q.we;
  assign mem_addr_o  = bus_q.addr;
  assign mem_wdata_o = bus_q.wdata;
  assign valid_o     = rsp_q.vld;
  assign result_o    = rsp_q.result;
  assign wbf_o       = rsp_q.wbf;
  assign rd_o        = rsp_q.rd;
  assign err_o       = rsp_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      bus_q <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (memf_i) begin
              state       <= BUS;
              cnt         <= '0;
              rd_q        <= rd_i;
              bus_q.req   <= 1'b1;
              bus_q.we    <= write_i;
              bus_q.addr  <= addr_i;
              bus_q.wdata <= data_i;
              rsp_q.vld   <= 1'b0;
            end else begin
              rsp_q.vld    <= 1'b1;
              rsp_q.result <= res_i;
              rsp_q.wbf    <= wbf_i;
              rsp_q.rd     <= rd_i;
              rsp_q.err    <= 1'b0;
            end
          end else if (rsp_q.vld && ready_i) begin
            rsp_q.vld <= 1'b0;
          end
        end
        BUS: begin
          if (mem_ack_i || tmo) begin
            state     <= IDLE;
            bus_q     <= '0;
            rsp_q.vld <= 1'b1;
            rsp_q.rd  <= rd_q;
            rsp_q.err <= !mem_ack_i;
            // Only a completed load writes back; stores and aborts return zero.
            if (mem_ack_i && !bus_q.we) begin
              rsp_q.result <= mem_rdata_i;
              rsp_q.wbf    <= 1'b1;
            end else begin
              rsp_q.result <= '0;
              rsp_q.wbf    <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): pass-through, load, store,
// backpressure, timeout, ack-vs-timeout race and asynchronous reset mid-transaction.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, ready_o, memf_i = 1'b0, write_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [31:0] data_i = '0, res_i = '0;
  logic        wbf_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        valid_o, ready_i = 1'b1;
  logic [31:0] result_o;
  logic        wbf_o, err_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.W_OPR(32), .ADDR(16), .W_RD(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .memf_i(memf_i), .write_i(write_i), .addr_i(addr_i), .data_i(data_i),
    .res_i(res_i), .wbf_i(wbf_i), .rd_i(rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .wbf_o(wbf_o), .rd_o(rd_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic mf, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] r, input logic w,
                       input logic [4:0] rd);
    valid_i = 1'b1; memf_i = mf; write_i = wr; addr_i = a;
    data_i = d; res_i = r; wbf_i = w; rd_i = rd;
  endtask

  initial begin
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);

    // idle ack ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
    step();
    mem_ack_i = 1'b0;
    chk("idle_ack_valid", 64'(valid_o), 64'd0);
    chk("idle_ack_req", 64'(mem_req_o), 64'd0);

    // pass-through burst
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, 1'b0, 16'h0, 32'h0, 32'(i), 1'b1, 5'(i));
      chk("pt_ready", 64'(ready_o), 64'd1);
      step();
      chk("pt_valid", 64'(valid_o), 64'd1);
      chk("pt_result", 64'(result_o), 64'(i));
      chk("pt_rd", 64'(rd_o), 64'(i));
    end
    valid_i = 1'b0;
    step();
    chk("pt_drain", 64'(valid_o), 64'd0);

    // load, ack in third req cycle
    issue(1'b1, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b0, 5'd7);
    step();
    valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ld_req", 64'(mem_req_o), 64'd1);
      chk("ld_addr", 64'(mem_addr_o), 64'h10);
      chk("ld_we", 64'(mem_we_o), 64'd0);
      chk("ld_ready", 64'(ready_o), 64'd0);
      chk("ld_nvalid", 64'(valid_o), 64'd0);
      if (c == 2) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; end
      step();
    end
    mem_ack_i = 1'b0;
    chk("ld_valid", 64'(valid_o), 64'd1);
    chk("ld_result", 64'(result_o), 64'hDEADBEEF);
    chk("ld_wbf", 64'(wbf_o), 64'd1);
    chk("ld_rd", 64'(rd_o), 64'd7);
    chk("ld_err", 64'(err_o), 64'd0);
    chk("ld_req_off", 64'(mem_req_o), 64'd0);
    step();
    chk("ld_drain", 64'(valid_o), 64'd0);

    // store, ack in first BUS cycle
    issue(1'b1, 1'b1, 16'h00FF, 32'h12345678, 32'h0, 1'b1, 5'd2);
    step();
    valid_i = 1'b0;
    chk("st_req", 64'(mem_req_o), 64'd1);
    chk("st_we", 64'(mem_we_o), 64'd1);
    chk("st_addr", 64'(mem_addr_o), 64'hFF);
    chk("st_wdata", 64'(mem_wdata_o), 64'h12345678);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    step();
    mem_ack_i = 1'b0;
    chk("st_valid", 64'(valid_o), 64'd1);
    chk("st_wbf", 64'(wbf_o), 64'd0);
    chk("st_result", 64'(result_o), 64'd0);
    chk("st_we_off", 64'(mem_we_o), 64'd0);
    chk("st_addr_off", 64'(mem_addr_o), 64'd0);
    step();

    // downstream backpressure
    ready_i = 1'b0;
    issue(1'b0, 1'b0, 16'h0, 32'h0, 32'hAA, 1'b1, 5'd3);
    step();
    issue(1'b0, 1'b0, 16'h0, 32'h0, 32'hBB, 1'b0, 5'd4);
    for (int c = 0; c < 2; c++) begin
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_result", 64'(result_o), 64'hAA);
      chk("bp_rd", 64'(rd_o), 64'd3);
      chk("bp_ready", 64'(ready_o), 64'd0);
      step();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_ready_up", 64'(ready_o), 64'd1);
    step();
    valid_i = 1'b0;
    chk("bp_next", 64'(result_o), 64'hBB);
    chk("bp_next_wbf", 64'(wbf_o), 64'd0);
    step();
    chk("bp_drain", 64'(valid_o), 64'd0);

    // timeout, no ack
    issue(1'b1, 1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 5'd9);
    step();
    valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_req", 64'(mem_req_o), 64'd1);
      step();
    end
    chk("to_req_off", 64'(mem_req_o), 64'd0);
    chk("to_valid", 64'(valid_o), 64'd1);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_wbf", 64'(wbf_o), 64'd0);
    chk("to_result", 64'(result_o), 64'd0);
    chk("to_rd", 64'(rd_o), 64'd9);
    step();

    // ack in the cycle the timeout would fire
    issue(1'b1, 1'b0, 16'h0030, 32'h0, 32'h0, 1'b0, 5'd10);
    step();
    valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("race_req", 64'(mem_req_o), 64'd1);
      if (c == 3) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; end
      step();
    end
    mem_ack_i = 1'b0;
    chk("race_err", 64'(err_o), 64'd0);
    chk("race_result", 64'(result_o), 64'hCAFEF00D);
    chk("race_wbf", 64'(wbf_o), 64'd1);
    chk("race_rd", 64'(rd_o), 64'd10);
    step();

    // asynchronous reset during the second req cycle
    issue(1'b1, 1'b0, 16'h0040, 32'h0, 32'h0, 1'b0, 5'd1);
    step();
    valid_i = 1'b0;
    step();
    chk("rr_req_pre", 64'(mem_req_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req", 64'(mem_req_o), 64'd0);
    chk("rr_valid", 64'(valid_o), 64'd0);
    #4 rst_n = 1'b1;
    #1;
    chk("rr_ready", 64'(ready_o), 64'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    step();
    mem_ack_i = 1'b0;
    chk("rr_ack_valid", 64'(valid_o), 64'd0);
    chk("rr_ack_req", 64'(mem_req_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule
